// File: rtl/img_pkg.sv
// Shared constants and FSM state encoding for the padded frame writer.
package img_pkg;

    localparam int PIX_W      = 8;
    localparam int IMG_DIM    = 64;
    localparam int PAD_DIM    = 66;
    localparam int BORDER_CNT = 260;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pad_ram.sv
// Padded image store: one write port, one registered read port, array has no reset.
// Latency: 1 cycle read, out-of-range addresses read as zero; write-before-read returns old data.
// Backpressure: none, accepts one write and one read every cycle.
module pad_ram #(
    parameter int PIX_W   = 8,
    parameter int PAD_DIM = 66
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [6:0]       wr_row,
    input  logic [6:0]       wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [6:0]       rd_row,
    input  logic [6:0]       rd_col,
    output logic [PIX_W-1:0] rd_data
);
    localparam int DEPTH = PAD_DIM * PAD_DIM;
    localparam int IW    = $clog2(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             rd_in_range;
    logic [PIX_W-1:0] rd_data_d;
    logic [PIX_W-1:0] rd_data_q;

    assign wr_idx      = IW'(wr_row) * IW'(PAD_DIM) + IW'(wr_col);
    assign rd_idx      = IW'(rd_row) * IW'(PAD_DIM) + IW'(rd_col);
    assign rd_in_range = (rd_row < 7'(PAD_DIM)) && (rd_col < 7'(PAD_DIM));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_in_range ? mem[rd_idx] : '0;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rd_n_ok(rst_n)) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    function automatic logic rd_n_ok(input logic n);
        return n;
    endfunction

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pad_frame_writer.sv
// Frame writer: zeroes the 1-pixel border, then streams raster pixels into the interior.
// Latency: border clear takes 4*IMG_DIM+4 cycles, one pixel per accepted cycle, 1-cycle done pulse.
// Backpressure: pixel_ready high only while loading; pixel_valid low simply holds the counters.
module pad_frame_writer import img_pkg::*; #(
    parameter int PIX_W   = img_pkg::PIX_W,
    parameter int IMG_DIM = img_pkg::IMG_DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic             busy,
    output logic             frame_done,
    input  logic             rd_en,
    input  logic [6:0]       rd_row,
    input  logic [6:0]       rd_col,
    output logic [PIX_W-1:0] rd_data
);
    localparam int PAD_SIDE = IMG_DIM + 2;
    localparam int BRD_CNT  = 4 * IMG_DIM + 4;
    localparam int CW       = $clog2(IMG_DIM);
    localparam int BW       = $clog2(BRD_CNT);

    state_t           state_q, state_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [CW-1:0]    prow_q, prow_d;
    logic [CW-1:0]    pcol_q, pcol_d;
    logic [6:0]       brd_row, brd_col;
    logic             wr_en;
    logic [6:0]       wr_row, wr_col;
    logic [PIX_W-1:0] wr_data;

    // Border walk: top row, bottom row, then left and right columns without corners.
    always_comb begin
        brd_row = '0;
        brd_col = '0;
        if (bcnt_q < BW'(PAD_SIDE)) begin
            brd_col = 7'(bcnt_q);
        end else if (bcnt_q < BW'(2 * PAD_SIDE)) begin
            brd_row = 7'(PAD_SIDE - 1);
            brd_col = 7'(bcnt_q - BW'(PAD_SIDE));
        end else if (bcnt_q < BW'(2 * PAD_SIDE + IMG_DIM)) begin
            brd_row = 7'(bcnt_q - BW'(2 * PAD_SIDE - 1));
        end else begin
            brd_row = 7'(bcnt_q - BW'(2 * PAD_SIDE + IMG_DIM - 1));
            brd_col = 7'(PAD_SIDE - 1);
        end
    end

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        prow_d      = prow_q;
        pcol_d      = pcol_q;
        wr_en       = 1'b0;
        wr_row      = '0;
        wr_col      = '0;
        wr_data     = pixel_in;
        pixel_ready = 1'b0;
        busy        = (state_q != ST_IDLE);
        frame_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    bcnt_d  = '0;
                    prow_d  = '0;
                    pcol_d  = '0;
                end
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_row  = brd_row;
                wr_col  = brd_col;
                wr_data = '0;
                if (bcnt_q == BW'(BRD_CNT - 1)) begin
                    bcnt_d  = '0;
                    state_d = ST_LOAD;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                pixel_ready = 1'b1;
                if (pixel_valid) begin
                    wr_en  = 1'b1;
                    wr_row = 7'(prow_q) + 7'd1;
                    wr_col = 7'(pcol_q) + 7'd1;
                    if (pcol_q == CW'(IMG_DIM - 1)) begin
                        pcol_d = '0;
                        if (prow_q == CW'(IMG_DIM - 1)) begin
                            prow_d  = '0;
                            state_d = ST_DONE;
                        end else begin
                            prow_d = prow_q + 1'b1;
                        end
                    end else begin
                        pcol_d = pcol_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            prow_q  <= '0;
            pcol_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
        end
    end

    pad_ram #(
        .PIX_W   (PIX_W),
        .PAD_DIM (PAD_SIDE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_pad_frame_writer.sv
// Randomized self-checking bench for pad_frame_writer against a 66x66 array reference image.
module tb_pad_frame_writer;

    localparam int PAD  = 66;
    localparam int IMG  = 64;
    localparam int NPIX = IMG * IMG;
    localparam int NBRD = 260;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pixel_in = '0;
    logic       pixel_valid = 1'b0;
    logic       pixel_ready;
    logic       busy;
    logic       frame_done;
    logic       rd_en = 1'b0;
    logic [6:0] rd_row = '0;
    logic [6:0] rd_col = '0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [0:PAD-1][0:PAD-1];

    pad_frame_writer #(.PIX_W(8), .IMG_DIM(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input int r, input int c);
        if (r >= PAD || c >= PAD) return 8'h00;
        return model[r][c];
    endfunction

    function automatic logic [31:0] status_word();
        return 32'({busy, pixel_ready, frame_done});
    endfunction

    task automatic clear_border_model();
        for (int c = 0; c < PAD; c++) begin
            model[0][c]     = 8'h00;
            model[PAD-1][c] = 8'h00;
            model[c][0]     = 8'h00;
            model[c][PAD-1] = 8'h00;
        end
    endtask

    // Issue one read from a negedge and return what the port shows one edge later.
    task automatic do_read(input int r, input int c, output logic [7:0] val);
        @(negedge clk);
        rd_en  = 1'b1;
        rd_row = 7'(r);
        rd_col = 7'(c);
        @(negedge clk);
        rd_en = 1'b0;
        val   = rd_data;
    endtask

    task automatic rand_reads(input string tag, input int cnt);
        logic [7:0] v;
        int r, c;
        for (int i = 0; i < cnt; i++) begin
            r = $urandom_range(0, 70);
            c = $urandom_range(0, 70);
            do_read(r, c, v);
            chk_eq(tag, 32'(v), 32'(model_rd(r, c)));
        end
    endtask

    // One frame: start pulse, clear phase, pixel stream, done pulse, checked every cycle.
    task automatic run_frame(input string tag, input int vld_pct, input bit ramp,
                             input logic [7:0] fill, input int abort_at,
                             input bit glitch, input bit sc_read, input int exp_busy);
        int clear_left, n, cyc, busy_cyc, done_cnt, load_cyc;
        bit fin, pend_sc, exp_ready, exp_done, xfer;
        logic [7:0] sc_old;
        clear_left = NBRD; n = 0; cyc = 0; busy_cyc = 0; done_cnt = 0; load_cyc = 0;
        fin = 0; pend_sc = 0; sc_old = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 20000) begin
            exp_ready = (clear_left == 0) && (n < NPIX);
            exp_done  = (clear_left == 0) && (n == NPIX);
            chk_eq({tag, "_status"}, status_word(), 32'({1'b1, exp_ready, exp_done}));
            busy_cyc += int'(busy);
            done_cnt += int'(frame_done);
            load_cyc += int'(exp_ready);
            if (pend_sc) begin
                chk_eq({tag, "_same_cycle_rd"}, 32'(rd_data), 32'(sc_old));
                pend_sc = 0;
            end
            rd_en = 1'b0;
            if (abort_at >= 0 && exp_ready && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_eq({tag, "_abort_outs"}, 32'({pixel_ready, busy, frame_done, rd_data}), 32'h0);
                pixel_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            pixel_valid = ($urandom_range(0, 99) < vld_pct);
            pixel_in    = ramp ? (n[7:0] ^ fill) : fill;
            start       = glitch && exp_ready && n >= 100 && n < 103;
            if (sc_read && exp_ready && n == 0) begin
                pixel_valid = 1'b1;
                rd_en  = 1'b1;
                rd_row = 7'd1;
                rd_col = 7'd1;
                sc_old = model[1][1];
                pend_sc = 1;
            end
            xfer = exp_ready && pixel_valid;
            @(posedge clk);
            if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) clear_border_model();
            end else if (xfer) begin
                model[n / IMG + 1][n % IMG + 1] = pixel_in;
                n++;
            end else if (n == NPIX) begin
                fin = 1;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        pixel_valid = 1'b0;
        if (cyc >= 20000) chk_eq({tag, "_timeout"}, 32'd1, 32'd0);
        chk_eq({tag, "_idle_after"}, status_word(), 32'h0);
        chk_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk_eq({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(NBRD + load_cyc + 1));
        if (exp_busy > 0) chk_eq({tag, "_busy_exact"}, 32'(busy_cyc), 32'(exp_busy));
    endtask

    initial begin
        logic [7:0] v;
        repeat (3) @(negedge clk);
        chk_eq("rst_outs", 32'({pixel_ready, busy, frame_done, rd_data}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("idle_outs", status_word(), 32'h0);

        // Full-rate ramp frame: border and interior mapping.
        run_frame("frame_a", 100, 1'b1, 8'h00, -1, 1'b0, 1'b0, NBRD + NPIX + 1);
        do_read(0, 0, v);   chk_eq("brd_0_0",   32'(v), 32'h00);
        do_read(0, 65, v);  chk_eq("brd_0_65",  32'(v), 32'h00);
        do_read(65, 33, v); chk_eq("brd_65_33", 32'(v), 32'h00);
        do_read(40, 0, v);  chk_eq("brd_40_0",  32'(v), 32'h00);
        do_read(1, 1, v);   chk_eq("int_1_1",   32'(v), 32'h00);
        do_read(1, 64, v);  chk_eq("int_1_64",  32'(v), 32'h3F);
        do_read(64, 64, v); chk_eq("int_64_64", 32'(v), 32'hFF);
        do_read(2, 1, v);   chk_eq("int_2_1",   32'(v), 32'h40);
        rd_row = 7'd0;
        rd_col = 7'd0;
        repeat (3) @(negedge clk);
        chk_eq("rd_hold", 32'(rd_data), 32'h40);
        do_read(66, 5, v);  chk_eq("rd_row_66", 32'(v), 32'h00);
        do_read(7, 70, v);  chk_eq("rd_col_70", 32'(v), 32'h00);
        rand_reads("frame_a_rand", 40);

        // Inverted ramp with a read of (1,1) on the very edge that overwrites it.
        run_frame("frame_b", 100, 1'b1, 8'hFF, -1, 1'b0, 1'b1, NBRD + NPIX + 1);
        do_read(1, 1, v);   chk_eq("b_int_1_1", 32'(v), 32'hFF);
        rand_reads("frame_b_rand", 40);

        // Stalled ramp with start glitched mid-load; image must match the full-rate result.
        run_frame("frame_c", 50, 1'b1, 8'h00, -1, 1'b1, 1'b0, 0);
        do_read(1, 1, v);   chk_eq("c_int_1_1",   32'(v), 32'h00);
        do_read(1, 64, v);  chk_eq("c_int_1_64",  32'(v), 32'h3F);
        do_read(2, 1, v);   chk_eq("c_int_2_1",   32'(v), 32'h40);
        do_read(64, 64, v); chk_eq("c_int_64_64", 32'(v), 32'hFF);
        rand_reads("frame_c_rand", 60);

        // Leave rd_data non-zero so the abort check shows it being forced low.
        do_read(1, 64, v);
        run_frame("frame_d", 100, 1'b0, 8'h11, 1000, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk_eq("post_abort_idle", status_word(), 32'h0);

        run_frame("frame_e", 100, 1'b0, 8'hAA, -1, 1'b0, 1'b0, NBRD + NPIX + 1);
        do_read(33, 33, v); chk_eq("e_int_33_33", 32'(v), 32'hAA);
        do_read(0, 17, v);  chk_eq("e_brd_0_17",  32'(v), 32'h00);
        rand_reads("frame_e_rand", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
